// File: rtl/led_pattern_seq_if.sv
// Control inputs and LED/status outputs of the LED pattern sequencer.
// The sequencer binds to the slave modport; the driving side uses master.
interface led_pattern_seq_if #(
    parameter int N_LED = 4
);
    localparam int STEP_W = $clog2(N_LED);

    logic              run;
    logic              auto_mode;
    logic [1:0]        mode_sel;
    logic [N_LED-1:0]  led;
    logic [1:0]        pattern;
    logic [STEP_W-1:0] step;
    logic              phase_done;

    modport master (
        output run, auto_mode, mode_sel,
        input  led, pattern, step, phase_done
    );

    modport slave (
        input  run, auto_mode, mode_sel,
        output led, pattern, step, phase_done
    );
endinterface

// File: rtl/led_pattern_seq.sv
// LED light-bar sequencer: prescaled step tick walks FILL/DRAIN/BLINK/CHASE; led is 1 cycle behind step/pattern.
// No backpressure: run=0 freezes prescaler, step and pattern; manual mode_sel changes restart the phase at once.
module led_pattern_seq #(
    parameter int N_LED       = 4,
    parameter int TICK_CYCLES = 100_000_000
) (
    input  logic              clk,
    input  logic              rst_n,
    led_pattern_seq_if.slave  bus
);
    localparam int CNT_W  = $clog2(TICK_CYCLES);
    localparam int STEP_W = $clog2(N_LED);

    typedef enum logic [1:0] {
        PAT_FILL  = 2'd0,
        PAT_DRAIN = 2'd1,
        PAT_BLINK = 2'd2,
        PAT_CHASE = 2'd3
    } pat_e;

    logic [CNT_W-1:0]  cnt_q,  cnt_d;
    logic [STEP_W-1:0] step_q, step_d;
    pat_e              pat_q,  pat_d;
    logic [N_LED-1:0]  led_q,  led_d;
    logic              done_q, done_d;

    logic tick;
    logic restart;
    logic last_step;

    assign tick      = bus.run && (cnt_q == CNT_W'(TICK_CYCLES - 1));
    assign last_step = (step_q == STEP_W'(N_LED - 1));
    // Checked every cycle, even while paused, so a manual pick never waits on run.
    assign restart   = !bus.auto_mode && (bus.mode_sel != pat_q);

    always_comb begin
        cnt_d  = cnt_q;
        step_d = step_q;
        pat_d  = pat_q;
        done_d = 1'b0;
        if (restart) begin
            pat_d  = pat_e'(bus.mode_sel);
            step_d = '0;
            cnt_d  = '0;
        end else if (tick) begin
            cnt_d = '0;
            if (last_step) begin
                step_d = '0;
                done_d = 1'b1;
                pat_d  = bus.auto_mode ? pat_e'(pat_q + 2'd1) : pat_e'(bus.mode_sel);
            end else begin
                step_d = step_q + STEP_W'(1);
            end
        end else if (bus.run) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Decode works on the registered state, giving led its one-cycle lag.
    always_comb begin
        int k;
        k     = int'(step_q);
        led_d = '0;
        for (int i = 0; i < N_LED; i++) begin
            case (pat_q)
                PAT_FILL:  led_d[i] = (i <= k);
                PAT_DRAIN: led_d[i] = ((i + k) < (N_LED - 1));
                PAT_BLINK: led_d[i] = ~step_q[0];
                default:   led_d[i] = (i == k);
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            step_q <= '0;
            pat_q  <= PAT_FILL;
            led_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            step_q <= step_d;
            pat_q  <= pat_d;
            led_q  <= led_d;
            done_q <= done_d;
        end
    end

    assign bus.led        = led_q;
    assign bus.pattern    = pat_q;
    assign bus.step       = step_q;
    assign bus.phase_done = done_q;
endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq: a 4-LED/4-cycle instance for most scenarios,
// and an 8-LED/3-cycle instance for the wide-bar checks.
module tb_led_pattern_seq;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic rst2_n;

    led_pattern_seq_if #(.N_LED(4)) bus ();
    led_pattern_seq_if #(.N_LED(8)) bus2 ();

    led_pattern_seq #(.N_LED(4), .TICK_CYCLES(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    led_pattern_seq #(.N_LED(8), .TICK_CYCLES(3)) dut8 (
        .clk   (clk),
        .rst_n (rst2_n),
        .bus   (bus2.slave)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic       run;
        logic       auto_mode;
        logic [1:0] mode_sel;
        int         ncyc;
        logic [3:0] led;
        logic [1:0] pat;
        logic [1:0] stp;
        logic       done;
    } vec_t;

    vec_t tbl[21];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk4(input string nm, input logic [3:0] l, input logic [1:0] p,
                        input logic [1:0] s, input logic d);
        chk({nm, ".led"},  bus.led,        l);
        chk({nm, ".pat"},  bus.pattern,    p);
        chk({nm, ".step"}, bus.step,       s);
        chk({nm, ".done"}, bus.phase_done, d);
    endtask

    // Leaves the bench on a negedge with reset just released; next posedge is edge 1.
    task automatic reset4(input logic r, input logic a, input logic [1:0] m);
        @(negedge clk);
        rst_n         = 1'b0;
        bus.run       = r;
        bus.auto_mode = a;
        bus.mode_sel  = m;
        wait_n(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        rst2_n         = 1'b0;
        bus.run        = 1'b0;
        bus.auto_mode  = 1'b1;
        bus.mode_sel   = 2'd0;
        bus2.run       = 1'b1;
        bus2.auto_mode = 1'b1;
        bus2.mode_sel  = 2'd0;

        // Checkpoints at edges 1,5,9,13,16,17,...,64,65 after reset release.
        tbl[0]  = '{1, 1, 0, 1, 4'b0001, 0, 0, 0};
        tbl[1]  = '{1, 1, 0, 4, 4'b0011, 0, 1, 0};
        tbl[2]  = '{1, 1, 0, 4, 4'b0111, 0, 2, 0};
        tbl[3]  = '{1, 1, 0, 4, 4'b1111, 0, 3, 0};
        tbl[4]  = '{1, 1, 0, 3, 4'b1111, 1, 0, 1};
        tbl[5]  = '{1, 1, 0, 1, 4'b0111, 1, 0, 0};
        tbl[6]  = '{1, 1, 0, 4, 4'b0011, 1, 1, 0};
        tbl[7]  = '{1, 1, 0, 4, 4'b0001, 1, 2, 0};
        tbl[8]  = '{1, 1, 0, 4, 4'b0000, 1, 3, 0};
        tbl[9]  = '{1, 1, 0, 3, 4'b0000, 2, 0, 1};
        tbl[10] = '{1, 1, 0, 1, 4'b1111, 2, 0, 0};
        tbl[11] = '{1, 1, 0, 4, 4'b0000, 2, 1, 0};
        tbl[12] = '{1, 1, 0, 4, 4'b1111, 2, 2, 0};
        tbl[13] = '{1, 1, 0, 4, 4'b0000, 2, 3, 0};
        tbl[14] = '{1, 1, 0, 3, 4'b0000, 3, 0, 1};
        tbl[15] = '{1, 1, 0, 1, 4'b0001, 3, 0, 0};
        tbl[16] = '{1, 1, 0, 4, 4'b0010, 3, 1, 0};
        tbl[17] = '{1, 1, 0, 4, 4'b0100, 3, 2, 0};
        tbl[18] = '{1, 1, 0, 4, 4'b1000, 3, 3, 0};
        tbl[19] = '{1, 1, 0, 3, 4'b1000, 0, 0, 1};
        tbl[20] = '{1, 1, 0, 1, 4'b0001, 0, 0, 0};

        // Reset state
        wait_n(2);
        chk4("reset", 4'b0000, 2'd0, 2'd0, 1'b0);

        // Auto rotation through all four patterns and the wrap back to FILL
        reset4(1'b1, 1'b1, 2'd0);
        for (int i = 0; i < 21; i++) begin
            bus.run       = tbl[i].run;
            bus.auto_mode = tbl[i].auto_mode;
            bus.mode_sel  = tbl[i].mode_sel;
            wait_n(tbl[i].ncyc);
            chk4($sformatf("auto[%0d]", i), tbl[i].led, tbl[i].pat, tbl[i].stp, tbl[i].done);
        end

        // Pause during FILL step 2 (edge 9 leaves the prescaler at 1)
        reset4(1'b1, 1'b1, 2'd0);
        wait_n(9);
        bus.run = 1'b0;
        wait_n(10);
        chk4("pause", 4'b0111, 2'd0, 2'd2, 1'b0);
        bus.run = 1'b1;
        wait_n(2);
        chk("resume2.step", bus.step, 2'd2);
        wait_n(1);
        chk("resume3.step", bus.step, 2'd3);
        chk("resume3.led", bus.led, 4'b0111);
        wait_n(1);
        chk("resume4.led", bus.led, 4'b1111);

        // Manual switch to CHASE at FILL step 1
        reset4(1'b1, 1'b1, 2'd0);
        wait_n(5);
        bus.auto_mode = 1'b0;
        bus.mode_sel  = 2'd3;
        wait_n(1);
        chk4("manual.edge", 4'b0011, 2'd3, 2'd0, 1'b0);
        wait_n(1);
        chk("manual.led", bus.led, 4'b0001);
        wait_n(15);
        chk4("manual.wrap", 4'b1000, 2'd3, 2'd0, 1'b1);
        wait_n(1);
        chk4("manual.again", 4'b0001, 2'd3, 2'd0, 1'b0);

        // Mode change on the same cycle as the phase-ending tick
        reset4(1'b1, 1'b1, 2'd0);
        wait_n(15);
        chk("pre_race.step", bus.step, 2'd3);
        bus.auto_mode = 1'b0;
        bus.mode_sel  = 2'd2;
        wait_n(1);
        chk4("race", 4'b1111, 2'd2, 2'd0, 1'b0);
        wait_n(1);
        chk("race.led", bus.led, 4'b1111);
        wait_n(3);
        chk("race.cnt_restart", bus.step, 2'd1);

        // Asynchronous reset in the middle of BLINK
        reset4(1'b1, 1'b1, 2'd0);
        wait_n(38);
        chk("blink.pat", bus.pattern, 2'd2);
        #1 rst_n = 1'b0;
        #1;
        chk4("async_rst", 4'b0000, 2'd0, 2'd0, 1'b0);

        // Eight LEDs, three cycles per step
        @(negedge clk);
        rst2_n = 1'b1;
        wait_n(1);
        chk("w8.e1.led", bus2.led, 8'h01);
        wait_n(2);
        chk("w8.e3.led", bus2.led, 8'h01);
        wait_n(1);
        chk("w8.e4.led", bus2.led, 8'h03);
        wait_n(20);
        chk("w8.fill_end.led", bus2.led, 8'hFF);
        chk("w8.fill_end.pat", bus2.pattern, 2'd1);
        chk("w8.fill_end.done", bus2.phase_done, 1'b1);
        wait_n(19);
        chk("w8.drain6.led", bus2.led, 8'h01);
        wait_n(5);
        chk("w8.drain_end.led", bus2.led, 8'h00);
        chk("w8.drain_end.done", bus2.phase_done, 1'b1);
        wait_n(48);
        chk("w8.chase_end.led", bus2.led, 8'h80);
        chk("w8.chase_end.pat", bus2.pattern, 2'd0);
        chk("w8.chase_end.done", bus2.phase_done, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
